// File: rtl/cpu_sdr_bridge.sv
// cpu_sdr_bridge: turns a level-held CPU bus cycle (cs/rd/wr) into a single
// req/ack handshake towards an SDRAM controller. The CPU gets `ready` once the
// SDRAM side has acknowledged. A write to a non-writable region is dropped
// without touching the SDRAM.
//
// Optional feature: define CPU_SDR_CACHE_EN to add a single-entry read cache
// (one tag, one data word, one valid bit). A read hit completes without an
// SDRAM request. Writes to the cached address merge into the cached word.
module cpu_sdr_bridge (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [24:1] addr,
    input  logic        writable,
    input  logic [1:0]  be,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        ready,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic [24:1] sdr_addr,
    output logic        sdr_we,
    output logic [1:0]  sdr_be,
    output logic [15:0] sdr_wdata,
    input  logic [15:0] sdr_q
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;

    // The ack that ends a request; acks in any other state are stale or spurious.
    logic ack_in_req;
    assign ack_in_req = (state == REQ) && sdr_ack;

`ifdef CPU_SDR_CACHE_EN
    logic        cache_vld;
    logic [24:1] cache_tag;
    logic [15:0] cache_data;
    logic        read_hit;

    // Byte-lane merge of new write data into an existing word.
    function automatic logic [15:0] merge_be(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  lanes);
        merge_be[15:8] = lanes[1] ? new_word[15:8] : old_word[15:8];
        merge_be[7:0]  = lanes[0] ? new_word[7:0]  : old_word[7:0];
    endfunction

    // Only reads may hit; a write always goes through to the SDRAM (or is dropped).
    assign read_hit = cache_vld && (cache_tag == addr) && !wr;

    // Valid bit: cleared by reset, set by the first completed read.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld <= 1'b0;
        end else if (ack_in_req && !sdr_we) begin
            cache_vld <= 1'b1;
        end
    end

    // Tag/data: fill on a read ack, merge on a write ack to the tagged address.
    always_ff @(posedge clk_sys) begin
        if (ack_in_req) begin
            if (!sdr_we) begin
                cache_tag  <= sdr_addr;
                cache_data <= sdr_q;
            end else if (cache_vld && (cache_tag == sdr_addr)) begin
                cache_data <= merge_be(cache_data, sdr_wdata, sdr_be);
            end
        end
    end
`endif

    // Bus-cycle FSM; every output is registered here.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sdr_req   <= 1'b0;
            ready     <= 1'b0;
            dout      <= 16'h0000;
            sdr_addr  <= '0;
            sdr_we    <= 1'b0;
            sdr_be    <= 2'b00;
            sdr_wdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (cs && (rd || wr)) begin
                        // wr wins when both strobes are high
                        sdr_addr  <= addr;
                        sdr_we    <= wr;
                        sdr_be    <= be;
                        sdr_wdata <= din;
                        if (wr && !writable) begin
                            // ROM write: complete the CPU cycle, drop the data
                            ready <= 1'b1;
                            state <= DONE;
`ifdef CPU_SDR_CACHE_EN
                        end else if (read_hit) begin
                            dout  <= cache_data;
                            ready <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            sdr_req <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    // cs may drop here; the request still runs to completion
                    if (sdr_ack) begin
                        sdr_req <= 1'b0;
                        ready   <= 1'b1;
                        if (!sdr_we) begin
                            dout <= sdr_q;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // wait for the CPU to end its cycle; restart only from IDLE
                    if (!rd && !wr) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// Self-checking bench for cpu_sdr_bridge. The reference model holds the SDRAM
// contents as an associative array and, for the cache build, only the
// currently cached address. Define CPU_SDR_CACHE_EN to check the cache build.
module tb_cpu_sdr_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, writable = 1'b0;
    logic [24:1] addr = '0;
    logic [1:0]  be = 2'b00;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        ready, sdr_req, sdr_we;
    logic        sdr_ack = 1'b0;
    logic [24:1] sdr_addr;
    logic [1:0]  sdr_be;
    logic [15:0] sdr_wdata;
    logic [15:0] sdr_q = 16'h0000;

    cpu_sdr_bridge dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cs(cs), .rd(rd), .wr(wr),
        .addr(addr), .writable(writable), .be(be), .din(din), .dout(dout),
        .ready(ready), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
        .sdr_addr(sdr_addr), .sdr_we(sdr_we), .sdr_be(sdr_be),
        .sdr_wdata(sdr_wdata), .sdr_q(sdr_q)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [15:0] mem [logic [24:1]];
    logic        m_vld = 1'b0;
    logic [24:1] m_tag = '0;
    logic [15:0] last_dout = 16'h0000;

    // results of the most recent access
    logic        r_req, r_rdy_first, r_req_after, r_rdy_done;
    bit          r_fields_ok;
    int          r_req_cycles;
    logic [15:0] r_dout;

    function automatic bit model_hit(input logic [24:1] a);
`ifdef CPU_SDR_CACHE_EN
        return m_vld && (m_tag == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] merged(input logic [15:0] old_w,
                                           input logic [15:0] d,
                                           input logic [1:0]  b);
        logic [15:0] hi, lo;
        hi = b[1] ? (d & 16'hFF00) : (old_w & 16'hFF00);
        lo = b[0] ? (d & 16'h00FF) : (old_w & 16'h00FF);
        return hi | lo;
    endfunction

    // Runs one CPU access up to the point where ready is observed; the SDRAM
    // side acks after dly extra request cycles with data q.
    task automatic run_access(input logic w, input logic r, input logic [24:1] a,
                              input logic [1:0] b, input logic [15:0] d,
                              input logic wbl, input int dly, input logic [15:0] q,
                              input bit drop_cs);
        cs = 1'b1; rd = r; wr = w; addr = a; be = b; din = d; writable = wbl;
        @(posedge clk_sys); #1;
        // scramble the inputs: the bridge must hold its latched copies
        addr = 24'($urandom); be = 2'($urandom); din = 16'($urandom);
        if (drop_cs) cs = 1'b0;
        r_req = sdr_req; r_rdy_first = ready; r_fields_ok = 1'b1;
        r_req_cycles = 0; r_req_after = 1'b0;
        if (sdr_req === 1'b1) begin
            for (int i = 0; i <= dly; i++) begin
                if (sdr_req !== 1'b1 || ready !== 1'b0 || sdr_addr !== a ||
                    sdr_we !== w || sdr_be !== b || sdr_wdata !== d)
                    r_fields_ok = 1'b0;
                r_req_cycles++;
                if (i == dly) begin sdr_ack = 1'b1; sdr_q = q; end
                @(posedge clk_sys); #1;
            end
            sdr_ack = 1'b0; sdr_q = 16'($urandom);
            r_req_after = sdr_req;
        end
        r_rdy_done = ready; r_dout = dout;
    endtask

    task automatic end_access();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset();
        cs = 1'b1; rd = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        n_cmp++; if (sdr_req !== 1'b0 || ready !== 1'b0) begin n_err++;
            $display("FAIL reset_ctrl: req=%b ready=%b, required 0 0", sdr_req, ready); end
        n_cmp++; if (dout !== 16'h0000) begin n_err++;
            $display("FAIL reset_dout: got %h, required 0000", dout); end
        n_cmp++; if ({sdr_addr, sdr_we, sdr_be, sdr_wdata} !== 43'd0) begin n_err++;
            $display("FAIL reset_fields: addr=%h we=%b be=%b wdata=%h, required all 0",
                     sdr_addr, sdr_we, sdr_be, sdr_wdata); end
        cs = 1'b0; rd = 1'b0;
        reset_n = 1'b1;
        @(posedge clk_sys); #1;
        n_cmp++; if (sdr_req !== 1'b0 || ready !== 1'b0) begin n_err++;
            $display("FAIL post_reset_idle: req=%b ready=%b, required 0 0", sdr_req, ready); end
    endtask

    task automatic test_read();
        mem[24'h000100] = 16'hBEEF;
        run_access(1'b0, 1'b1, 24'h000100, 2'b11, 16'h0000, 1'b1, 5, mem[24'h000100], 1'b0);
        n_cmp++; if (r_req !== 1'b1 || r_rdy_first !== 1'b0) begin n_err++;
            $display("FAIL read_start: req=%b ready=%b, required 1 0", r_req, r_rdy_first); end
        n_cmp++; if (!r_fields_ok || r_req_cycles != 6) begin n_err++;
            $display("FAIL read_req_hold: ok=%0d cycles=%0d, required 1 6", r_fields_ok, r_req_cycles); end
        n_cmp++; if (r_req_after !== 1'b0 || r_rdy_done !== 1'b1) begin n_err++;
            $display("FAIL read_ack: req=%b ready=%b, required 0 1", r_req_after, r_rdy_done); end
        n_cmp++; if (r_dout !== 16'hBEEF) begin n_err++;
            $display("FAIL read_data: got %h, required BEEF", r_dout); end
        m_vld = 1'b1; m_tag = 24'h000100; last_dout = 16'hBEEF;
        // hold rd; a stray ack during DONE must change nothing
        for (int i = 0; i < 3; i++) begin
            sdr_ack = (i == 1); sdr_q = 16'h1234;
            @(posedge clk_sys); #1;
            sdr_ack = 1'b0;
            n_cmp++; if (ready !== 1'b1 || dout !== 16'hBEEF || sdr_req !== 1'b0) begin n_err++;
                $display("FAIL read_hold: ready=%b dout=%h req=%b, required 1 BEEF 0", ready, dout, sdr_req); end
        end
        end_access();
        n_cmp++; if (ready !== 1'b0) begin n_err++;
            $display("FAIL read_release: ready=%b, required 0", ready); end
    endtask

    task automatic test_write();
        logic [24:1] a;
        a = 24'h000321;
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        run_access(1'b1, 1'b0, a, 2'b01, 16'h12AB, 1'b1, 3, 16'hDEAD, 1'b0);
        n_cmp++; if (r_req !== 1'b1 || !r_fields_ok) begin n_err++;
            $display("FAIL write_req: req=%b fields_ok=%0d, required 1 1", r_req, r_fields_ok); end
        n_cmp++; if (r_rdy_done !== 1'b1 || r_req_after !== 1'b0) begin n_err++;
            $display("FAIL write_ack: ready=%b req=%b, required 1 0", r_rdy_done, r_req_after); end
        n_cmp++; if (r_dout !== last_dout) begin n_err++;
            $display("FAIL write_dout: got %h, required %h", r_dout, last_dout); end
        mem[a] = merged(mem[a], 16'h12AB, 2'b01);
        end_access();
    endtask

    task automatic test_rom_write();
        run_access(1'b1, 1'b0, 24'h000400, 2'b11, 16'h7777, 1'b0, 2, 16'h0000, 1'b0);
        n_cmp++; if (r_req !== 1'b0 || r_rdy_first !== 1'b1) begin n_err++;
            $display("FAIL rom_write: req=%b ready=%b, required 0 1", r_req, r_rdy_first); end
        @(posedge clk_sys); #1;
        n_cmp++; if (sdr_req !== 1'b0 || dout !== last_dout) begin n_err++;
            $display("FAIL rom_write_hold: req=%b dout=%h, required 0 %h", sdr_req, dout, last_dout); end
        end_access();
    endtask

    task automatic test_rd_wr_both();
        logic [24:1] a;
        logic [15:0] d;
        a = 24'h000555; d = 16'($urandom);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        run_access(1'b1, 1'b1, a, 2'b11, d, 1'b1, 1, 16'hF00D, 1'b0);
        n_cmp++; if (r_req !== 1'b1 || !r_fields_ok || r_dout !== last_dout) begin n_err++;
            $display("FAIL rd_wr_both: req=%b fields_ok=%0d dout=%h, required 1 1 %h",
                     r_req, r_fields_ok, r_dout, last_dout); end
        mem[a] = merged(mem[a], d, 2'b11);
        end_access();
    endtask

    task automatic test_cs_drop_and_idle_ack();
        logic [24:1] a;
        a = 24'h000777;
        mem[a] = 16'($urandom);
        run_access(1'b0, 1'b1, a, 2'b11, 16'h0000, 1'b1, 2, mem[a], 1'b1);
        n_cmp++; if (r_req !== 1'b1 || r_rdy_done !== 1'b1 || r_dout !== mem[a]) begin n_err++;
            $display("FAIL cs_drop: req=%b ready=%b dout=%h, required 1 1 %h",
                     r_req, r_rdy_done, r_dout, mem[a]); end
        m_vld = 1'b1; m_tag = a; last_dout = mem[a];
        end_access();
        sdr_ack = 1'b1; sdr_q = ~last_dout;
        @(posedge clk_sys); #1;
        sdr_ack = 1'b0;
        @(posedge clk_sys); #1;
        n_cmp++; if (sdr_req !== 1'b0 || ready !== 1'b0 || dout !== last_dout) begin n_err++;
            $display("FAIL idle_ack: req=%b ready=%b dout=%h, required 0 0 %h",
                     sdr_req, ready, dout, last_dout); end
    endtask

    task automatic test_reset_mid_req();
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 24'hABCDE0; writable = 1'b1;
        @(posedge clk_sys); #1;
        n_cmp++; if (sdr_req !== 1'b1) begin n_err++;
            $display("FAIL rst_mid_start: req=%b, required 1", sdr_req); end
        repeat (2) begin @(posedge clk_sys); #1; end
        reset_n = 1'b0; cs = 1'b0; rd = 1'b0;
        #1;
        n_cmp++; if (sdr_req !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_async: req=%b, required 0", sdr_req); end
        repeat (2) begin @(posedge clk_sys); #1; end
        reset_n = 1'b1;
        m_vld = 1'b0; last_dout = 16'h0000;
        @(posedge clk_sys); #1;
        sdr_ack = 1'b1; sdr_q = 16'h4321;
        @(posedge clk_sys); #1;
        sdr_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (sdr_req !== 1'b0 || ready !== 1'b0 || dout !== 16'h0000 ||
                         {sdr_addr, sdr_we, sdr_be, sdr_wdata} !== 43'd0) begin n_err++;
                $display("FAIL rst_mid_after: req=%b ready=%b dout=%h addr=%h, required 0 0 0000 000000",
                         sdr_req, ready, dout, sdr_addr); end
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic test_cache();
        logic exp_hit;
        mem[24'h000200] = 16'h5555;
        exp_hit = model_hit(24'h000200);
        run_access(1'b0, 1'b1, 24'h000200, 2'b11, 16'h0000, 1'b1, 2, mem[24'h000200], 1'b0);
        n_cmp++; if (r_req !== !exp_hit || r_dout !== 16'h5555) begin n_err++;
            $display("FAIL cache_first_read: req=%b dout=%h, required %b 5555", r_req, r_dout, !exp_hit); end
        m_vld = 1'b1; m_tag = 24'h000200; last_dout = 16'h5555;
        end_access();
        run_access(1'b1, 1'b0, 24'h000200, 2'b10, 16'hAA00, 1'b1, 1, 16'h0000, 1'b0);
        mem[24'h000200] = merged(mem[24'h000200], 16'hAA00, 2'b10);
        end_access();
        exp_hit = model_hit(24'h000200);
        run_access(1'b0, 1'b1, 24'h000200, 2'b11, 16'h0000, 1'b1, 2, mem[24'h000200], 1'b0);
        n_cmp++; if (r_req !== !exp_hit || r_rdy_first !== exp_hit) begin n_err++;
            $display("FAIL cache_second_req: req=%b ready=%b, required %b %b",
                     r_req, r_rdy_first, !exp_hit, exp_hit); end
        n_cmp++; if (r_dout !== 16'hAA55) begin n_err++;
            $display("FAIL cache_merge: got %h, required AA55", r_dout); end
        last_dout = 16'hAA55;
        end_access();
    endtask

    task automatic test_random();
        logic [24:1] pool [4];
        pool[0] = 24'h000010; pool[1] = 24'h000011; pool[2] = 24'h123456; pool[3] = 24'hFFFFFF;
        for (int it = 0; it < 60; it++) begin
            int          op, dly;
            logic        w, r, wbl, exp_req, hit;
            logic [24:1] a;
            logic [1:0]  b;
            logic [15:0] d, exp_dout;
            op = $urandom_range(0, 3); dly = $urandom_range(0, 4);
            a = pool[$urandom_range(0, 3)]; b = 2'($urandom); d = 16'($urandom);
            case (op)
                0:       begin w = 1'b0; r = 1'b1; wbl = 1'($urandom); end
                1:       begin w = 1'b1; r = 1'b0; wbl = 1'b1; end
                2:       begin w = 1'b1; r = 1'b0; wbl = 1'b0; end
                default: begin w = 1'b1; r = 1'b1; wbl = 1'b1; end
            endcase
            if (!mem.exists(a)) mem[a] = 16'($urandom);
            hit = model_hit(a);
            exp_req  = w ? wbl : !hit;
            exp_dout = w ? last_dout : mem[a];
            run_access(w, r, a, b, d, wbl, dly, mem[a], 1'b0);
            n_cmp++; if (r_req !== exp_req || r_rdy_first !== !exp_req) begin n_err++;
                $display("FAIL rand_start[%0d]: op=%0d req=%b ready=%b, required %b %b",
                         it, op, r_req, r_rdy_first, exp_req, !exp_req); end
            n_cmp++; if (!r_fields_ok || r_req_after !== 1'b0 || r_rdy_done !== 1'b1) begin n_err++;
                $display("FAIL rand_handshake[%0d]: fields_ok=%0d req=%b ready=%b, required 1 0 1",
                         it, r_fields_ok, r_req_after, r_rdy_done); end
            n_cmp++; if (r_dout !== exp_dout) begin n_err++;
                $display("FAIL rand_dout[%0d]: op=%0d addr=%h got %h, required %h",
                         it, op, a, r_dout, exp_dout); end
            if (!w && !hit) begin m_vld = 1'b1; m_tag = a; end
            if (w && wbl) mem[a] = merged(mem[a], d, b);
            last_dout = exp_dout;
            end_access();
            n_cmp++; if (ready !== 1'b0) begin n_err++;
                $display("FAIL rand_release[%0d]: ready=%b, required 0", it, ready); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_rom_write();
        test_rd_wr_both();
        test_cs_drop_and_idle_ack();
        test_reset_mid_req();
        test_cache();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_sdr_bridge.md
CPU_SDR_BRIDGE -- requirements
Module: cpu_sdr_bridge

Interface
REQ-001 SHALL have port clk_sys, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cs, input, 1, decoded memory select (ls245_en from address decode).
REQ-004 SHALL have ports rd and wr, input, 1 each, CPU read and write strobes, level, held for the whole bus cycle.
REQ-005 SHALL have port addr, input, 24 ([24:1]), decoded SDRAM word address.
REQ-006 SHALL have port writable, input, 1, region accepts writes.
REQ-007 SHALL have ports be (input, 2, byte enables [1]=hi [0]=lo), din (input, 16, write data) and dout (output, 16, read data).
REQ-008 SHALL have port ready, output, 1, CPU may complete the cycle.
REQ-009 SHALL have SDRAM-side ports: sdr_req out 1, sdr_ack in 1, sdr_addr out 24, sdr_we out 1, sdr_be out 2, sdr_wdata out 16, sdr_q in 16.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, DONE.
REQ-011 In IDLE, cs&rd or cs&wr sampled high SHALL start an access; if rd and wr are both high, wr SHALL win.
REQ-012 A write with writable=0 SHALL go directly to DONE without an SDRAM request (ROM write dropped).
REQ-013 On start, sdr_addr, sdr_we, sdr_be and sdr_wdata SHALL latch addr, wr, be and din, and sdr_req SHALL rise the next cycle; the FSM SHALL enter REQ.
REQ-014 sdr_req SHALL stay high and the latched fields SHALL stay stable until a cycle with sdr_ack=1; sdr_ack is a single-cycle pulse.
REQ-015 On sdr_ack in REQ: sdr_req SHALL fall the same edge, dout SHALL latch sdr_q for reads, and the FSM SHALL enter DONE.
REQ-016 dout SHALL be unchanged by writes.
REQ-017 ready SHALL be 1 in DONE only, registered, so the earliest ready is one cycle after the ack edge.
REQ-018 DONE SHALL hold until rd and wr are both low, then return to IDLE; no new access SHALL start in the same cycle.
REQ-019 cs falling while in REQ SHALL NOT abort the request; the access completes normally.
REQ-020 sdr_ack outside REQ SHALL be ignored.

Reset
REQ-021 reset_n low SHALL force: state IDLE, sdr_req 0, ready 0, dout 0, sdr_addr 0, sdr_we 0, sdr_be 0, sdr_wdata 0, cache invalid.
REQ-022 reset mid-REQ SHALL drop sdr_req immediately (asynchronously); a later stale sdr_ack SHALL be ignored per REQ-020.

Configuration
REQ-023 Macro CPU_SDR_CACHE_EN SHALL select a single-entry read cache: one tag (addr[24:1]), one data word and one valid bit.
REQ-024 With the macro, a read whose addr matches a valid tag SHALL go to DONE without an sdr_req and present the cached word on dout, giving ready one cycle after start.
REQ-025 With the macro, a read miss SHALL fill the cache on ack.
REQ-026 With the macro, a write to the tagged addr SHALL merge din into the cached word per be; writes to other addresses SHALL leave the cache unchanged.
REQ-027 Without the macro, every read SHALL issue an SDRAM request; no cache storage SHALL exist.

Verification
REQ-028 Read: cs=1, rd=1, addr=0x000100; ack after 5 cycles with sdr_q=0xBEEF -> sdr_req high exactly until the ack edge; dout=0xBEEF and ready=1 next cycle; ready stays 1 until rd falls.
REQ-029 Write: cs=1, wr=1, writable=1, be=2'b01, din=0x12AB -> sdr_we=1, sdr_be=01, sdr_wdata=0x12AB held until ack; dout unchanged.
REQ-030 ROM write: wr=1, writable=0 -> sdr_req never asserts; ready=1 one cycle after start.
REQ-031 Reset mid-REQ: reset_n low 2 cycles after sdr_req rises, then ack pulse arrives after release -> sdr_req drops at once; outputs at reset values; FSM stays IDLE and ready stays 0.
REQ-032 Cache (CPU_SDR_CACHE_EN): read 0x000200 (sdr_q=0x5555); write be=2'b10, din=0xAA00 to 0x000200; read 0x000200 again -> second read has no sdr_req and returns 0xAA55. Without the macro the second read issues sdr_req.
REQ-033 rd and wr both high with cs=1 -> treated as a write (sdr_we=1).
